// File: rtl/pc_unit.sv
// Program counter stage: holds the fetch PC and selects sequential (+4) or redirect
// next PC, deferring a redirect until the current fetch completes.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        br_take_i,
  input  logic [31:0] br_target_i,
  input  logic        if_ready_i,
  output logic        if_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misalign_err_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_tgt_q;
  logic        misalign_q;

  logic adv;
  logic tgt_ok;
  logic good_br;
  logic bad_br;

  assign if_valid_o     = (state_q != BOOT);
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_q + 32'd4;
  assign misalign_err_o = misalign_q;

  assign adv     = if_valid_o & if_ready_i & ~stall_i;
  assign tgt_ok  = (br_target_i[1:0] == 2'b00);
  assign good_br = br_take_i & tgt_ok;
  assign bad_br  = br_take_i & ~tgt_ok;

  // A misaligned redirect only raises the error; PC and state act as if no branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bad_br & (state_q != BOOT);
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (good_br && adv) begin
            pc_q <= br_target_i;
          end else if (good_br) begin
            pend_tgt_q <= br_target_i;
            state_q    <= PEND;
          end else if (adv) begin
            pc_q <= pc_plus4_o;
          end
        end
        PEND: begin
          if (good_br) begin
            // Latest redirect wins over the one already pending.
            pend_tgt_q <= br_target_i;
            if (adv) begin
              pc_q    <= br_target_i;
              state_q <= RUN;
            end
          end else if (adv) begin
            pc_q    <= pend_tgt_q;
            state_q <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues the expected post-edge state,
// and a monitor on the falling edge pops and compares it.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        m;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;

  pc_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .br_take_i     (br_take),
    .br_target_i   (br_target),
    .if_ready_i    (if_ready),
    .if_valid_o    (if_valid),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .misalign_err_o(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, id, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input logic r, input logic st, input logic bt,
                     input logic [31:0] tg, input logic rdy,
                     input logic [31:0] epc, input logic ev, input logic em);
    exp_t e;
    rst       = r;
    stall     = st;
    br_take   = bt;
    br_target = tg;
    if_ready  = rdy;
    @(posedge clk);
    #1;
    e.pc = epc;
    e.v  = ev;
    e.m  = em;
    e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",           e.id, pc,                   e.pc);
        chk("pc_plus4",     e.id, pc_plus4,             e.pc + 32'd4);
        chk("if_valid",     e.id, 32'(if_valid),        32'(e.v));
        chk("misalign_err", e.id, 32'(misalign_err),    32'(e.m));
      end
    end
  end

  initial begin
    // Reset held two cycles, then BOOT for one cycle with if_valid low.
    cyc(1, 0, 0, 32'h0,         1, 32'h100, 0, 0);
    cyc(1, 0, 0, 32'h0,         1, 32'h100, 0, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h100, 1, 0);
    // Sequential fetch.
    cyc(0, 0, 0, 32'h0,         1, 32'h104, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h108, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h10C, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h110, 1, 0);
    // Redirect under stall is deferred, then taken on first advance.
    cyc(0, 1, 1, 32'h200,       1, 32'h110, 1, 0);
    cyc(0, 1, 0, 32'h0,         1, 32'h110, 1, 0);
    cyc(0, 1, 0, 32'h0,         1, 32'h110, 1, 0);
    cyc(0, 1, 0, 32'h0,         1, 32'h110, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h200, 1, 0);
    // Two redirects while pending, with if_ready low acting as a stall.
    cyc(0, 1, 1, 32'h280,       1, 32'h200, 1, 0);
    cyc(0, 1, 1, 32'h300,       1, 32'h200, 1, 0);
    cyc(0, 0, 0, 32'h0,         0, 32'h200, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h300, 1, 0);
    // New redirect arriving in PEND on the advancing cycle.
    cyc(0, 1, 1, 32'h500,       1, 32'h300, 1, 0);
    cyc(0, 0, 1, 32'h600,       1, 32'h600, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h604, 1, 0);
    // Misaligned targets: one-cycle error, no redirect, nothing left pending.
    cyc(0, 0, 1, 32'h202,       1, 32'h608, 1, 1);
    cyc(0, 0, 0, 32'h0,         1, 32'h60C, 1, 0);
    cyc(0, 1, 1, 32'h203,       1, 32'h60C, 1, 1);
    cyc(0, 0, 0, 32'h0,         1, 32'h610, 1, 0);
    // Wrap around the top of the address space.
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 0);
    // Reset while a redirect is pending drops it.
    cyc(0, 1, 1, 32'h400,       1, 32'h4,   1, 0);
    cyc(1, 0, 1, 32'h202,       1, 32'h100, 0, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h100, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h104, 1, 0);
    cyc(0, 0, 0, 32'h0,         1, 32'h108, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
